// File: rtl/reg_dump_pkg.sv
// Shared constants and FSM state encoding for the register-file dump engine.
package reg_dump_pkg;

    localparam int ADDR_W   = 5;
    localparam int NREGS    = 32;
    localparam int ZERO_REG = 31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/reg_dump.sv
// Register-file dump engine: walks a (possibly wrapping) index range of a
// register file, presents each word on a valid/ready stream, and keeps a
// running XOR checksum of the words the consumer has accepted.
module reg_dump #(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  checksum
);

    import reg_dump_pkg::*;

    state_t            state_reg;
    logic [ADDR_W-1:0] last_sel_reg;

    // Handshake on the output stream.
    logic accept;
    assign accept = out_valid && out_ready;

    // Dump sequencer: one FETCH cycle samples the register file, then SEND
    // holds the word until accepted. The index increment wraps naturally at
    // the register count, so a last index below the first dumps through 31.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            last_sel_reg <= '0;
            rd_addr      <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_index    <= '0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            checksum     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        last_sel_reg <= last_reg;
                        rd_addr      <= first_reg;
                        checksum     <= '0;
                        busy         <= 1'b1;
                        state_reg    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    out_data  <= rd_data;
                    out_index <= rd_addr;
                    out_last  <= (rd_addr == last_sel_reg);
                    out_valid <= 1'b1;
                    state_reg <= ST_SEND;
                end
                ST_SEND: begin
                    if (accept) begin
                        checksum  <= checksum ^ out_data;
                        out_valid <= 1'b0;
                        if (out_last) begin
                            done      <= 1'b1;
                            state_reg <= ST_DONE;
                        end else begin
                            rd_addr   <= out_index + 1'b1;
                            state_reg <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// Directed self-checking bench for reg_dump with a behavioural register file.
module tb_reg_dump;

    localparam int WIDTH  = 64;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] first_reg;
    logic [ADDR_W-1:0] last_reg;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  checksum;

    logic [WIDTH-1:0] regs [32];

    int pass_cnt  = 0;
    int check_cnt = 0;

    always #5 clk = ~clk;

    // Register file with a hardwired zero register at index 31.
    assign rd_data = (rd_addr == 5'd31) ? '0 : regs[rd_addr];

    reg_dump #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] xval(input int i);
        logic [63:0] k;
        k = 64'h0000010204080001;
        return 64'(i) * k;
    endfunction

    // Waits for a word (bounded), checks it and the wait time, then accepts it.
    task automatic take_word(input int exp_idx, input logic [63:0] exp_data,
                             input logic exp_last, input int exp_wait);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check("valid", out_valid, 1'b1);
        check("wait", 64'(n), 64'(exp_wait));
        check("index", 64'(out_index), 64'(exp_idx));
        check("data", out_data, exp_data);
        check("last", 64'(out_last), 64'(exp_last));
        $display("word idx=%0d data=%h last=%0b", out_index, out_data, out_last);
        out_ready = 1'b1;
        step();
        check("valid_drop", out_valid, 1'b0);
    endtask

    task automatic start_dump(input int f, input int l);
        first_reg = ADDR_W'(f);
        last_reg  = ADDR_W'(l);
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    initial begin
        logic [63:0] cs;
        int idx;

        for (int i = 0; i < 31; i++) regs[i] = xval(i);
        regs[31] = 64'hFFFF_FFFF_FFFF_FFFF;

        reset = 1'b1; start = 1'b0; first_reg = '0; last_reg = '0; out_ready = 1'b1;
        step(); step();
        check("rst_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cs", checksum, 64'd0);
        check("rst_addr", 64'(rd_addr), 64'd0);
        check("rst_data", out_data, 64'd0);
        reset = 1'b0;
        step();

        // Full dump 0..30, ready always high: 2-cycle latency and throughput.
        start_dump(0, 30);
        check("busy_fetch", busy, 1'b1);
        cs = '0;
        for (int i = 0; i <= 30; i++) begin
            take_word(i, xval(i), (i == 30), 1);
            cs ^= xval(i);
        end
        check("done_pulse", done, 1'b1);
        check("busy_done", busy, 1'b1);
        step();
        check("done_clear", done, 1'b0);
        check("busy_clear", busy, 1'b0);
        check("cs_full", checksum, cs);
        step(); step();
        check("cs_hold", checksum, cs);

        // Wrapping dump 29..2 with a conflicting start held high throughout.
        start_dump(29, 2);
        start = 1'b1; first_reg = 5'd10; last_reg = 5'd10;
        cs = '0;
        for (int k = 0; k < 6; k++) begin
            idx = (29 + k) % 32;
            take_word(idx, (idx == 31) ? 64'd0 : xval(idx), (k == 5), 1);
            cs ^= (idx == 31) ? 64'd0 : xval(idx);
        end
        check("wrap_done", done, 1'b1);
        start = 1'b0;
        step();
        check("wrap_cs", checksum, cs);
        check("wrap_idle", busy, 1'b0);

        // Single-word dump.
        start_dump(5, 5);
        take_word(5, xval(5), 1'b1, 1);
        check("single_done", done, 1'b1);
        step();
        check("single_cs", checksum, xval(5));

        // Back-pressure on word 1, plus a register write during the dump.
        start_dump(0, 3);
        take_word(0, xval(0), 1'b0, 1);
        regs[2] = 64'hDEAD_BEEF_0BAD_F00D;
        out_ready = 1'b0;
        step();
        for (int c = 0; c < 3; c++) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_index", 64'(out_index), 64'd1);
            check("stall_data", out_data, xval(1));
            if (c < 2) step();
        end
        take_word(1, xval(1), 1'b0, 0);
        take_word(2, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, 1);
        take_word(3, xval(3), 1'b1, 1);
        check("stall_done", done, 1'b1);
        step();
        check("stall_cs", checksum, xval(0) ^ xval(1) ^ 64'hDEAD_BEEF_0BAD_F00D ^ xval(3));
        regs[2] = xval(2);

        // Reset in the middle of a dump aborts it silently.
        start_dump(0, 30);
        take_word(0, xval(0), 1'b0, 1);
        take_word(1, xval(1), 1'b0, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_cs", checksum, 64'd0);
        check("abort_done", done, 1'b0);
        step(); step();
        check("abort_nodone", done, 1'b0);
        start_dump(0, 1);
        take_word(0, xval(0), 1'b0, 1);
        take_word(1, xval(1), 1'b1, 1);
        check("rerun_done", done, 1'b1);
        step();
        check("rerun_cs", checksum, xval(0) ^ xval(1));

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
